// File: rtl/fpalu_issue_ctrl_pkg.sv
// Shared FPALU opcodes, default megafunction latencies and issue-controller state codes.
package fpalu_issue_ctrl_pkg;

  localparam logic [4:0] FOPADD   = 5'd0;
  localparam logic [4:0] FOPSUB   = 5'd1;
  localparam logic [4:0] FOPMUL   = 5'd2;
  localparam logic [4:0] FOPDIV   = 5'd3;
  localparam logic [4:0] FOPSQRT  = 5'd4;
  localparam logic [4:0] FOPABS   = 5'd5;
  localparam logic [4:0] FOPNEG   = 5'd6;
  localparam logic [4:0] FOPCEQ   = 5'd7;
  localparam logic [4:0] FOPCLT   = 5'd8;
  localparam logic [4:0] FOPCLE   = 5'd9;
  localparam logic [4:0] FOPCVTSW = 5'd10;
  localparam logic [4:0] FOPCVTWS = 5'd11;

  localparam int FP_LAT_ADD   = 7;
  localparam int FP_LAT_MUL   = 5;
  localparam int FP_LAT_DIV   = 6;
  localparam int FP_LAT_SQRT  = 16;
  localparam int FP_LAT_CMP   = 1;
  localparam int FP_LAT_CVTSW = 6;
  localparam int FP_LAT_CVTWS = 6;

  localparam logic [1:0] ST_FPI_IDLE = 2'd0;
  localparam logic [1:0] ST_FPI_WAIT = 2'd1;
  localparam logic [1:0] ST_FPI_DONE = 2'd2;

endpackage

// File: rtl/fpalu_issue_ctrl_lat_lut.sv
// Opcode -> pipeline latency lookup; ABS/NEG are combinational in the FPALU, unknown codes are illegal.
module fpalu_lat_lut
  import fpalu_issue_ctrl_pkg::*;
#(
  parameter int LAT_ADD   = FP_LAT_ADD,
  parameter int LAT_MUL   = FP_LAT_MUL,
  parameter int LAT_DIV   = FP_LAT_DIV,
  parameter int LAT_SQRT  = FP_LAT_SQRT,
  parameter int LAT_CMP   = FP_LAT_CMP,
  parameter int LAT_CVTSW = FP_LAT_CVTSW,
  parameter int LAT_CVTWS = FP_LAT_CVTWS,
  parameter int CNT_W     = 5
) (
  input  logic [4:0]       opcode_i,
  output logic [CNT_W-1:0] lat_o,
  output logic             illegal_o
);

  always_comb begin
    lat_o     = '0;
    illegal_o = 1'b0;
    case (opcode_i)
      FOPADD, FOPSUB:         lat_o = CNT_W'(LAT_ADD);
      FOPMUL:                 lat_o = CNT_W'(LAT_MUL);
      FOPDIV:                 lat_o = CNT_W'(LAT_DIV);
      FOPSQRT:                lat_o = CNT_W'(LAT_SQRT);
      FOPCEQ, FOPCLT, FOPCLE: lat_o = CNT_W'(LAT_CMP);
      FOPCVTSW:               lat_o = CNT_W'(LAT_CVTSW);
      FOPCVTWS:               lat_o = CNT_W'(LAT_CVTWS);
      FOPABS, FOPNEG:         lat_o = '0;
      default:                illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/fpalu_issue_ctrl.sv
// FPALU initiator: registers one request, holds operands for the op's latency, then captures the result.
module fpalu_issue_ctrl
  import fpalu_issue_ctrl_pkg::*;
#(
  parameter int LAT_ADD   = FP_LAT_ADD,
  parameter int LAT_MUL   = FP_LAT_MUL,
  parameter int LAT_DIV   = FP_LAT_DIV,
  parameter int LAT_SQRT  = FP_LAT_SQRT,
  parameter int LAT_CMP   = FP_LAT_CMP,
  parameter int LAT_CVTSW = FP_LAT_CVTSW,
  parameter int LAT_CVTWS = FP_LAT_CVTWS,
  parameter int CNT_W     = 5
) (
  input  logic        iclock,
  input  logic        ireset,
  input  logic        istart,
  input  logic [4:0]  iopcode,
  input  logic [31:0] irs1,
  input  logic [31:0] irs2,
  output logic [31:0] ofpa_dataa,
  output logic [31:0] ofpa_datab,
  output logic [4:0]  ofpa_control,
  input  logic [31:0] ifpa_result,
  input  logic        ifpa_nan,
  input  logic        ifpa_zero,
  input  logic        ifpa_overflow,
  input  logic        ifpa_underflow,
  input  logic        ifpa_comp,
  output logic        obusy,
  output logic        odone,
  output logic [31:0] oresult,
  output logic [3:0]  oflags,
  output logic        ocomp,
  output logic        oillegal
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      dataa_q, datab_q, result_q;
  logic [4:0]       control_q;
  logic [3:0]       flags_q;
  logic             comp_q, illegal_q, illegalPend_q;
  logic [CNT_W-1:0] lutLat;
  logic             lutIllegal;
  logic             accept, capture;

  fpalu_lat_lut #(
    .LAT_ADD  (LAT_ADD),
    .LAT_MUL  (LAT_MUL),
    .LAT_DIV  (LAT_DIV),
    .LAT_SQRT (LAT_SQRT),
    .LAT_CMP  (LAT_CMP),
    .LAT_CVTSW(LAT_CVTSW),
    .LAT_CVTWS(LAT_CVTWS),
    .CNT_W    (CNT_W)
  ) u_lat_lut (
    .opcode_i (iopcode),
    .lat_o    (lutLat),
    .illegal_o(lutIllegal)
  );

  assign accept  = (state_q == ST_FPI_IDLE) && istart;
  assign capture = (state_q == ST_FPI_WAIT) && (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_FPI_IDLE: begin
        if (istart) begin
          state_d = ST_FPI_WAIT;
          cnt_d   = lutLat;
        end
      end
      ST_FPI_WAIT: begin
        if (cnt_q == '0) state_d = ST_FPI_DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_FPI_DONE: state_d = ST_FPI_IDLE;
      default:     state_d = ST_FPI_IDLE;
    endcase
  end

  // Operand registers only load on acceptance so the FPALU output mux stays put until capture.
  always_ff @(posedge iclock) begin
    if (ireset) begin
      state_q       <= ST_FPI_IDLE;
      cnt_q         <= '0;
      dataa_q       <= '0;
      datab_q       <= '0;
      control_q     <= '0;
      result_q      <= '0;
      flags_q       <= '0;
      comp_q        <= 1'b0;
      illegal_q     <= 1'b0;
      illegalPend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        dataa_q       <= irs1;
        datab_q       <= irs2;
        control_q     <= iopcode;
        illegalPend_q <= lutIllegal;
        illegal_q     <= 1'b0;
      end
      if (capture) begin
        if (illegalPend_q) begin
          result_q  <= '0;
          flags_q   <= '0;
          comp_q    <= 1'b0;
          illegal_q <= 1'b1;
        end else begin
          result_q <= ifpa_result;
          flags_q  <= {ifpa_nan, ifpa_zero, ifpa_overflow, ifpa_underflow};
          comp_q   <= ifpa_comp;
        end
      end
    end
  end

  assign ofpa_dataa   = dataa_q;
  assign ofpa_datab   = datab_q;
  assign ofpa_control = control_q;
  assign obusy        = (state_q != ST_FPI_IDLE);
  assign odone        = (state_q == ST_FPI_DONE);
  assign oresult      = result_q;
  assign oflags       = flags_q;
  assign ocomp        = comp_q;
  assign oillegal     = illegal_q;

endmodule

// File: doc/fpalu_issue_ctrl.md
Name: fpalu_issue_ctrl

Overview:
- Initiator side of the floating-point ALU interface.
- Accepts one FP operation request from the datapath and drives the registered operands and opcode into the FPALU.
- Holds them stable for the selected megafunction's pipeline latency, then captures the result, flags and compare bit into output registers and pulses done.
- Sits between the FP register file/decode stage and the FPALU. Its busy output is the stall source for multi-cycle FP instructions.

Parameters:
- LAT_ADD, 7: add_sub latency in cycles (FOPADD, FOPSUB).
- LAT_MUL, 5: mul_s latency.
- LAT_DIV, 6: div_s latency.
- LAT_SQRT, 16: sqrt_s latency.
- LAT_CMP, 1: c_comp latency (FOPCEQ, FOPCLT, FOPCLE).
- LAT_CVTSW, 6: cvt_s_w latency.
- LAT_CVTWS, 6: cvt_w_s latency.
- CNT_W, 5: wait-counter width. Every LAT_* must be <= 2^CNT_W-1.

Ports:
- iclock, in, 1: clock.
- ireset, in, 1: synchronous active-high reset.
- istart, in, 1: request strobe, sampled only in IDLE.
- iopcode, in, 5: FOP* operation code.
- irs1, in, 32: operand A.
- irs2, in, 32: operand B.
- ofpa_dataa, out, 32: to FPALU idataa (registered).
- ofpa_datab, out, 32: to FPALU idatab (registered).
- ofpa_control, out, 5: to FPALU icontrol (registered).
- ifpa_result, in, 32: FPALU oresult.
- ifpa_nan, in, 1: FPALU onan.
- ifpa_zero, in, 1: FPALU ozero.
- ifpa_overflow, in, 1: FPALU ooverflow.
- ifpa_underflow, in, 1: FPALU ounderflow.
- ifpa_comp, in, 1: FPALU oCompResult.
- obusy, out, 1: high whenever state != IDLE.
- odone, out, 1: one-cycle pulse; result outputs are valid from this cycle.
- oresult, out, 32: captured result.
- oflags, out, 4: captured flags {nan, zero, overflow, underflow}.
- ocomp, out, 1: captured compare bit.
- oillegal, out, 1: high with odone when the opcode is not a FOP* code.

Behaviour:
- Reset: one clock, synchronous, active-high on ireset; no async path. All outputs and internal registers go to 0, state goes to IDLE.
- Reset mid-operation aborts the operation: no odone is produced. Stale FPALU pipeline contents are harmless because every capture waits the full latency.
- States: IDLE, WAIT, DONE.
- IDLE:
  - On istart=1 at an edge: register irs1/irs2/iopcode into ofpa_dataa/ofpa_datab/ofpa_control.
  - Load cnt with LAT(iopcode) and go to WAIT.
  - Latch the illegal bit for the opcode.
- LAT mapping:
  - ADD/SUB -> LAT_ADD; MUL -> LAT_MUL; DIV -> LAT_DIV; SQRT -> LAT_SQRT.
  - CEQ/CLT/CLE -> LAT_CMP; CVTSW -> LAT_CVTSW; CVTWS -> LAT_CVTWS.
  - ABS/NEG -> 0 (combinational); illegal opcodes -> 0.
- WAIT:
  - If cnt==0: capture ifpa_result, the flags and ifpa_comp into the output registers, and go to DONE.
  - Else decrement cnt.
  - For an illegal opcode: capture oresult=0, oflags=0, ocomp=0, and set oillegal=1.
- DONE: odone=1 for exactly this cycle, then go to IDLE unconditionally.
- Latency: with istart sampled at edge 0, the capture happens at edge L+1. odone is high in the cycle after edge L+1, which is L+2 cycles after the request.
- Operand/opcode hold: ofpa_* stay constant from edge 0 until the next accepted request. The FPALU output mux depends on icontrol, so it must not change before capture.
- istart while obusy=1, including during DONE, is ignored; no queueing.
- Changes on irs1/irs2/iopcode after acceptance have no effect.
- Capture-register persistence:
  - oresult/oflags/ocomp hold their values until the next capture.
  - oillegal clears at the next accepted request.
- Compare ops: oresult is whatever the FPALU returns (0); the answer is carried on ocomp.

Decomposition:
- New constants go in Parametros.v, beside the existing FOP* codes:
  - FP_LAT_* default latencies.
  - State encodings ST_FPI_IDLE/WAIT/DONE.
- One natural sub-module: fpalu_lat_lut, a combinational opcode -> {latency, illegal} lookup, parameterized by the LAT_* values.
- The bench uses a behavioural FPALU model with the same per-op latencies.

Test Plan:
- FOPADD, A=0x3FC00000 (1.5), B=0x40100000 (2.25) -> obusy for 9 cycles; odone 9 cycles after the start edge; oresult=0x40700000; oflags=0000.
- FOPMUL 0x40000000 x 0x40400000 -> odone at +7; oresult=0x40C00000. Then FOPSQRT A=0xBF800000 (-1.0) -> odone at +18; oflags[3] (nan)=1.
- FOPNEG A=0x3F800000 -> odone at +2; oresult=0xBF800000. Then FOPCLT A=1.0 (0x3F800000), B=2.0 (0x40000000) -> odone at +3; ocomp=1; oresult=0.
- FOPDIV 1.0/2.0 started; new istart with FOPADD pulsed at +3 and +7 -> both ignored; single odone at +8; oresult=0x3F000000; ofpa_control stays FOPDIV throughout.
- FOPSQRT started; ireset asserted at +5 for 1 cycle -> obusy=0, odone never pulses, outputs=0. A new FOPABS A=0xC0000000 -> oresult=0x40000000 at +2.
- Unused opcode 5'b11111 -> odone at +2; oillegal=1; oresult=0; the next legal op clears oillegal.
